fpa_accumulator: RTL and testbench

Sequential front/back-end for the combinational fpa adder. It consumes a stream of IEEE-754 single-precision words and drives fpa with number_A = running sum and number_B = incoming word. It registers fpa's {sign, exp, mantis} result as the new running sum. At end-of-stream it presents the total on a valid/ready output. The fpa instance lives in the parent and is wired through the fpa_* ports.

---
 rtl/fpa_pkg.sv | 19 +
 rtl/fpa_accumulator.sv | 137 +++++++++++++
 tb/tb_fpa_accumulator.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpa_pkg.sv
// Shared definitions for the fpa accumulator slice.
//   FP_W/EXP_W/MAN_W : IEEE-754 single-precision field widths
//   FP_POS_ZERO      : +0.0 encoding, the accumulator's idle value
//   state_t          : accumulator control states
package fpa_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/fpa_accumulator.sv
// Stream accumulator wrapped around an external combinational fpa adder.
// Sums a stream of single-precision words, one word per cycle, and presents
// the total plus a saturating element count on a valid/ready output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous abort, drops partial sum and pending result
//   in_valid/in_ready     input handshake; in_data word, in_last ends the stream
//   fpa_a, fpa_b          to adder: running sum and incoming word
//   fpa_sign/exp/mantis   adder result fields
//   out_valid/out_ready   result handshake; out_data total, out_count word count
module fpa_accumulator
    import fpa_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_data,
    input  logic              in_last,
    output logic [FP_W-1:0]   fpa_a,
    output logic [FP_W-1:0]   fpa_b,
    input  logic              fpa_sign,
    input  logic [EXP_W-1:0]  fpa_exp,
    input  logic [MAN_W-1:0]  fpa_mantis,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   out_data,
    output logic [CNT_W-1:0]  out_count
);

    state_t            state, state_nxt;
    logic [FP_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [CNT_W-1:0]  count_inc;
    logic              out_valid_nxt;
    logic [FP_W-1:0]   out_data_nxt;
    logic [CNT_W-1:0]  out_count_nxt;
    logic [FP_W-1:0]   sum;
    logic              accept;

    // Clamp at all-ones instead of wrapping; the sum itself keeps going.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign fpa_a     = acc;
    assign fpa_b     = in_data;
    assign sum       = {fpa_sign, fpa_exp, fpa_mantis};
    assign count_inc = sat_inc(count);

    // Held low during reset, while clear is asserted, and while a result waits.
    assign in_ready = rst_n & ~clear & (state != HOLD);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= FP_POS_ZERO;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_count <= out_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        count_nxt     = count;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_count_nxt = out_count;

        if (clear) begin
            state_nxt     = IDLE;
            acc_nxt       = FP_POS_ZERO;
            count_nxt     = '0;
            out_valid_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // First word is loaded directly so -0 and specials survive.
                    if (accept) begin
                        if (in_last) begin
                            out_data_nxt  = in_data;
                            out_count_nxt = CNT_W'(1);
                            out_valid_nxt = 1'b1;
                            state_nxt     = HOLD;
                        end else begin
                            acc_nxt   = in_data;
                            count_nxt = CNT_W'(1);
                            state_nxt = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            out_data_nxt  = sum;
                            out_count_nxt = count_inc;
                            out_valid_nxt = 1'b1;
                            acc_nxt       = FP_POS_ZERO;
                            count_nxt     = '0;
                            state_nxt     = HOLD;
                        end else begin
                            acc_nxt   = sum;
                            count_nxt = count_inc;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end
                end
                default: begin
                    state_nxt     = IDLE;
                    acc_nxt       = FP_POS_ZERO;
                    count_nxt     = '0;
                    out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpa_accumulator.sv
module tb_fpa_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    // Default-width instance
    logic        ir16, ov16, s16;
    logic [31:0] fa16, fb16, od16;
    logic [7:0]  e16;
    logic [22:0] m16;
    logic [15:0] oc16;

    // Narrow-counter instance sharing the same stimulus
    logic        ir2, ov2, s2;
    logic [31:0] fa2, fb2, od2;
    logic [7:0]  e2;
    logic [22:0] m2;
    logic [1:0]  oc2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          c16;
        int          c2;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] w [5];
        int          n;
        int          gap;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vec [7];

    always #5 clk = ~clk;

    fpa_accumulator #(.CNT_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(ir16), .in_data(in_data), .in_last(in_last),
        .fpa_a(fa16), .fpa_b(fb16),
        .fpa_sign(s16), .fpa_exp(e16), .fpa_mantis(m16),
        .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .out_count(oc16)
    );

    fpa_accumulator #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data), .in_last(in_last),
        .fpa_a(fa2), .fpa_b(fb2),
        .fpa_sign(s2), .fpa_exp(e2), .fpa_mantis(m2),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_count(oc2)
    );

    // Behavioural stand-in for the external adder (normal values and zero only).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'b0};
        else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'b0};
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    always_comb {s16, e16, m16} = fadd(fa16, fb16);
    always_comb {s2, e2, m2}    = fadd(fa2, fb2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Offer one word at a negedge; it is taken at the following posedge.
    task automatic send_word(input logic [31:0] w, input logic last);
        int t;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        #1;
        t = 0;
        while (!ir16 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("in_ready_wait", 32'(ir16), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input int n);
        exp_t e;
        e.data = d;
        e.c16  = (n > 65535) ? 65535 : n;
        e.c2   = (n > 3) ? 3 : n;
        sb.push_back(e);
    endtask

    task automatic drain();
        int   t;
        exp_t e;
        out_ready = 1'b1;
        t = 0;
        while (!ov16 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_wait", 32'(ov16), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got result %h, required none", od16);
        end else begin
            e = sb.pop_front();
            chk("out_data", od16, e.data);
            chk("out_count", 32'(oc16), 32'(e.c16));
            chk("out_data_w2", od2, e.data);
            chk("out_count_w2", 32'(oc2), 32'(e.c2));
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(ov16), 32'd0);
        chk("in_ready_after_hs", 32'(ir16), 32'd1);
    endtask

    initial begin
        logic [31:0] model;

        vec[0] = '{'{32'h3F80_0000, 32'h0, 32'h0, 32'h0, 32'h0}, 1, 0, 32'h3F80_0000};
        vec[1] = '{'{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0, 32'h0}, 3, 0, 32'h40C0_0000};
        vec[2] = '{'{32'h3FC0_0000, 32'hBF00_0000, 32'h0, 32'h0, 32'h0}, 2, 2, 32'h3F80_0000};
        vec[3] = '{'{32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0}, 1, 0, 32'h8000_0000};
        vec[4] = '{'{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, 5, 0, 32'h40A0_0000};
        vec[5] = '{'{32'h4000_0000, 32'hC000_0000, 32'h0, 32'h0, 32'h0}, 2, 0, 32'h0000_0000};
        vec[6] = '{'{32'h4040_0000, 32'h3F00_0000, 32'h0, 32'h0, 32'h0}, 2, 1, 32'h4060_0000};

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 32'(ir16), 32'd0);
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_out_data", od16, 32'd0);
        chk("rst_out_count", 32'(oc16), 32'd0);
        chk("rst_fpa_a", fa16, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(ir16), 32'd1);

        // Single word held with out_ready low
        send_word(32'h3F80_0000, 1'b1);
        push_exp(32'h3F80_0000, 1);
        chk("single_valid", 32'(ov16), 32'd1);
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ov16), 32'd1);
            chk("hold_data", od16, 32'h3F80_0000);
            chk("hold_count", 32'(oc16), 32'd1);
            chk("hold_in_ready", 32'(ir16), 32'd0);
        end
        drain();

        // Table-driven streams
        for (int i = 0; i < 7; i++) begin
            model = '0;
            for (int j = 0; j < vec[i].n; j++) begin
                send_word(vec[i].w[j], (j == vec[i].n - 1));
                model = (j == 0) ? vec[i].w[0] : fadd(model, vec[i].w[j]);
                if (j < vec[i].n - 1) begin
                    for (int g = 0; g < vec[i].gap; g++) begin
                        @(negedge clk);
                        chk("gap_acc", fa16, model);
                    end
                end
            end
            push_exp(vec[i].exp_data, vec[i].n);
            drain();
        end

        // Clear mid-stream with a word offered in the same cycle
        send_word(32'h3F80_0000, 1'b0);
        send_word(32'h4000_0000, 1'b0);
        chk("pre_clear_acc", fa16, 32'h4040_0000);
        in_valid = 1'b1;
        in_data  = 32'h4080_0000;
        in_last  = 1'b1;
        clear    = 1'b1;
        #1;
        chk("clear_in_ready", 32'(ir16), 32'd0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk("clear_out_valid", 32'(ov16), 32'd0);
        chk("clear_acc", fa16, 32'd0);
        chk("clear_in_ready_after", 32'(ir16), 32'd1);
        send_word(32'h3F00_0000, 1'b1);
        push_exp(32'h3F00_0000, 1);
        drain();

        // Clear drops a pending result
        send_word(32'h4000_0000, 1'b1);
        chk("hold_before_clear", 32'(ov16), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clear_hold_valid", 32'(ov16), 32'd0);
        chk("clear_hold_in_ready", 32'(ir16), 32'd1);

        // Async reset with a pending result
        send_word(32'h3F80_0000, 1'b1);
        chk("pend_count", 32'(oc16), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(ov16), 32'd0);
        chk("arst_out_count", 32'(oc16), 32'd0);
        chk("arst_out_count_w2", 32'(oc2), 32'd0);
        chk("arst_out_data", od16, 32'd0);
        chk("arst_in_ready", 32'(ir16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-stream, then a fresh stream
        send_word(32'h3F80_0000, 1'b0);
        send_word(32'h4000_0000, 1'b0);
        chk("mid_acc", fa16, 32'h4040_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_arst_acc", fa16, 32'd0);
        chk("mid_arst_in_ready", 32'(ir16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(32'h4040_0000, 1'b1);
        push_exp(32'h4040_0000, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
